// File: rtl/spi_mem_ctrl_pkg.sv
// Shared constants, FSM encoding and frame layout for the SPI SRAM controller.
package spi_mem_ctrl_pkg;

    localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
    localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
    localparam int unsigned FRAME_LEN     = 40;
    localparam int unsigned RX_FIRST_BIT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  data;
    } frame_t;

    function automatic frame_t build_frame(input logic we, input logic [23:0] addr,
                                           input logic [7:0] wdata);
        frame_t f;
        f.cmd  = we ? SPI_CMD_WRITE : SPI_CMD_READ;
        f.addr = addr;
        f.data = we ? wdata : 8'h00;
        return f;
    endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// SPI mode-0 bit engine: clock divider, 40-bit MSB-first TX shift, 8-bit RX capture.
module spi_mem_shifter
    import spi_mem_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  frame_t     frame,
    input  logic       spi_miso,
    output logic [7:0] rx_c,
    output logic       fin_c,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_ce
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_LEN - 1);
    localparam logic [5:0]       RX_FIRST = 6'(RX_FIRST_BIT);

    logic                 active_q, active_d;
    logic                 sclk_q, sclk_d;
    logic                 ce_q, ce_d;
    logic [39:0]          sr_q, sr_d;
    logic [6:0]           rx_q, rx_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [5:0]           bit_q, bit_d;
    logic                 phase_end_c;
    logic                 falling_c;

    assign phase_end_c = (div_q == DIV_LAST);
    assign falling_c   = active_q && sclk_q && phase_end_c;
    // Final falling edge happens at the end of this cycle; rx_c is the byte it completes.
    assign fin_c       = falling_c && (bit_q == BIT_LAST);
    assign rx_c        = {rx_q, spi_miso};

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        ce_d     = ce_q;
        sr_d     = sr_q;
        rx_d     = rx_q;
        div_d    = div_q;
        bit_d    = bit_q;
        if (start) begin
            active_d = 1'b1;
            ce_d     = 1'b0;
            sclk_d   = 1'b0;
            sr_d     = frame;
            div_d    = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (phase_end_c) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    sr_d = {sr_q[38:0], 1'b0};
                    if (bit_q >= RX_FIRST) begin
                        rx_d = rx_c[6:0];
                    end
                    if (fin_c) begin
                        active_d = 1'b0;
                        ce_d     = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            ce_q     <= 1'b1;
            sr_q     <= '0;
            rx_q     <= '0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            ce_q     <= ce_d;
            sr_q     <= sr_d;
            rx_q     <= rx_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign spi_clk  = sclk_q;
    assign spi_mosi = sr_q[FRAME_LEN-1];
    assign spi_ce   = ce_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI SRAM sequencer with round-robin arbitration between fetch and data ports.
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CE_GAP  = 2,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ce
);

    localparam int unsigned      GAP_W    = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CE_GAP - 1);

    state_e           state_q, state_d;
    logic             last_data_q, last_data_d;
    logic             own_data_q, own_data_d;
    logic             we_q, we_d;
    frame_t           frame_q, frame_d;
    logic             start_q, start_d;
    logic             if_gnt_q, if_gnt_d;
    logic             d_gnt_q, d_gnt_d;
    logic             if_done_q, if_done_d;
    logic             d_done_q, d_done_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pick_data_c;
    logic [7:0]       rx_c;
    logic             fin_c;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        own_data_d  = own_data_q;
        we_d        = we_q;
        frame_d     = frame_q;
        start_d     = 1'b0;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        rdata_d     = rdata_q;
        gap_d       = gap_q;
        // On contention the port not granted last wins; reset leaves the data port favoured.
        pick_data_c = d_req && (!if_req || !last_data_q);
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    last_data_d = pick_data_c;
                    own_data_d  = pick_data_c;
                    we_d        = pick_data_c && d_we;
                    frame_d     = pick_data_c ? build_frame(d_we, 24'(d_addr), d_wdata)
                                              : build_frame(1'b0, 24'(if_addr), 8'h00);
                    if_gnt_d    = !pick_data_c;
                    d_gnt_d     = pick_data_c;
                    start_d     = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fin_c) begin
                    if_done_d = !own_data_q;
                    d_done_d  = own_data_q;
                    if (!we_q) begin
                        rdata_d = rx_c;
                    end
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            own_data_q  <= 1'b0;
            we_q        <= 1'b0;
            frame_q     <= '0;
            start_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            own_data_q  <= own_data_d;
            we_q        <= we_d;
            frame_q     <= frame_d;
            start_q     <= start_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            gap_q       <= gap_d;
        end
    end

    spi_mem_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .frame    (frame_q),
        .spi_miso (spi_miso),
        .rx_c     (rx_c),
        .fin_c    (fin_c),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_ce   (spi_ce)
    );

    assign if_gnt  = if_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign if_done = if_done_q;
    assign d_done  = d_done_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: CLK_DIV=1 instance for protocol/arbitration, CLK_DIV=3 for timing.
module tb_spi_mem_ctrl;

    logic clk, rst_n;
    logic if_req, if_gnt, if_done, d_req, d_we, d_gnt, d_done, busy;
    logic [15:0] if_addr, d_addr;
    logic [7:0]  d_wdata, rdata;
    logic spi_clk, spi_mosi, spi_miso, spi_ce;
    logic if_req3, if_gnt3, if_done3, d_gnt3, d_done3, busy3;
    logic [15:0] if_addr3;
    logic [7:0]  rdata3;
    logic spi_clk3, spi_mosi3, spi_miso3, spi_ce3;

    logic [7:0] mem [4];
    int n_cmp = 0;
    int n_bad = 0;

    spi_mem_ctrl #(.CLK_DIV(1), .CE_GAP(2), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata), .busy(busy),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ce(spi_ce)
    );

    spi_mem_ctrl #(.CLK_DIV(3), .CE_GAP(2), .ADDR_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_done(if_done3),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(8'h00),
        .d_gnt(d_gnt3), .d_done(d_done3), .rdata(rdata3), .busy(busy3),
        .spi_clk(spi_clk3), .spi_mosi(spi_mosi3), .spi_miso(spi_miso3), .spi_ce(spi_ce3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI SRAM model for the CLK_DIV=1 instance: captures MOSI, drives read data on rising edges.
    int          m1_n = 0;
    logic [39:0] m1_sh = '0;
    logic [39:0] m1_frame = '0;
    logic [7:0]  m1_rd = '0;
    initial spi_miso = 1'b0;
    always @(negedge spi_ce) m1_n = 0;
    always @(posedge spi_clk) if (!spi_ce) begin
        if (m1_n == 32) m1_rd = mem[m1_sh[1:0]];
        m1_sh = {m1_sh[38:0], spi_mosi};
        if (m1_n >= 32) spi_miso = m1_rd[7 - (m1_n - 32)];
        m1_n++;
    end
    always @(posedge spi_ce) if (m1_n == 40) m1_frame = m1_sh;

    int          m3_n = 0;
    logic [39:0] m3_sh = '0;
    logic [39:0] m3_frame = '0;
    logic [7:0]  m3_rd = '0;
    initial spi_miso3 = 1'b0;
    always @(negedge spi_ce3) m3_n = 0;
    always @(posedge spi_clk3) if (!spi_ce3) begin
        if (m3_n == 32) m3_rd = mem[m3_sh[1:0]];
        m3_sh = {m3_sh[38:0], spi_mosi3};
        if (m3_n >= 32) spi_miso3 = m3_rd[7 - (m3_n - 32)];
        m3_n++;
    end
    always @(posedge spi_ce3) if (m3_n == 40) m3_frame = m3_sh;

    // Event monitor, sampled on the falling clk edge.
    int         cyc = 0, gnt_cyc = 0, done_cyc = 0, dones = 0, hi_run = 0, last_gap = 0;
    int         gnt3_cyc = 0, done3_cyc = 0, dones3 = 0;
    int         run3 = 0, rmin3 = 999, rmax3 = 0, viol3 = 0;
    logic       rv3 = 1'b0, pclk3 = 1'b0, pmosi3 = 1'b0;
    logic [7:0] glog [$];
    always @(negedge clk) begin
        cyc++;
        if (if_gnt) begin glog.push_back(8'h46); gnt_cyc = cyc; end
        if (d_gnt)  begin glog.push_back(8'h44); gnt_cyc = cyc; end
        if (if_done || d_done) begin dones++; done_cyc = cyc; end
        if (spi_ce) hi_run++;
        else if (hi_run != 0) begin last_gap = hi_run; hi_run = 0; end
        if (if_gnt3) gnt3_cyc = cyc;
        if (if_done3) begin dones3++; done3_cyc = cyc; end
        if (spi_ce3) begin
            run3 = 0;
            rv3  = 1'b0;
        end else if (spi_clk3 != pclk3) begin
            if (rv3) begin
                if (run3 < rmin3) rmin3 = run3;
                if (run3 > rmax3) rmax3 = run3;
            end
            run3 = 1;
            rv3  = 1'b1;
        end else begin
            run3++;
        end
        if (!spi_ce3 && spi_clk3 && (spi_mosi3 != pmosi3)) viol3++;
        pclk3  = spi_clk3;
        pmosi3 = spi_mosi3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input string tag, input int target);
        int n = 0;
        while (dones < target && n < 1000) begin tick(); n++; end
        if (dones < target) chk(tag, 64'(dones), 64'(target));
    endtask

    logic [7:0] exp_seq [6];

    initial begin
        mem[0] = 8'h3E; mem[1] = 8'h03; mem[2] = 8'h26; mem[3] = 8'h00;
        exp_seq = '{8'h44, 8'h46, 8'h44, 8'h46, 8'h44, 8'h46};
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req3 = 1'b0; if_addr3 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_ce", 64'(spi_ce), 64'd1);
        chk("rst_sclk", 64'(spi_clk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_pulses", 64'({if_gnt, d_gnt, if_done, d_done}), 64'd0);

        // Simultaneous requests after reset: data port first.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd1;
        if_req = 1'b1; if_addr = 16'd2;
        wait_dones("t2_d_timeout", 1);
        d_req = 1'b0;
        chk("t2_first_gnt", 64'(glog[0]), 64'h44);
        chk("t2_rdata_d", 64'(rdata), 64'h03);
        wait_dones("t2_f_timeout", 2);
        if_req = 1'b0;
        chk("t2_second_gnt", 64'(glog[1]), 64'h46);
        chk("t2_rdata_f", 64'(rdata), 64'h26);
        chk("t2_ce_gap", 64'(last_gap >= 2), 64'd1);

        // Fairness with both requests held.
        repeat (4) tick();
        glog.delete();
        d_addr = 16'd0; if_addr = 16'd1;
        d_req = 1'b1; if_req = 1'b1;
        wait_dones("t4_timeout", 8);
        d_req = 1'b0; if_req = 1'b0;
        for (int i = 0; i < 6; i++) chk("t4_gnt_order", 64'(glog[i]), 64'(exp_seq[i]));

        // Write frame.
        repeat (4) tick();
        d_we = 1'b1; d_addr = 16'h1234; d_wdata = 8'hA5; d_req = 1'b1;
        wait_dones("t3_timeout", 9);
        d_req = 1'b0; d_we = 1'b0;
        chk("t3_gnt", 64'(glog[6]), 64'h44);
        chk("t3_frame", 64'(m1_frame), 64'h02_001234_A5);
        chk("t3_rdata_hold", 64'(rdata), 64'h03);

        // Fetch only.
        repeat (4) tick();
        if_addr = 16'd0; if_req = 1'b1;
        wait_dones("t1_timeout", 10);
        if_req = 1'b0;
        chk("t1_rdata", 64'(rdata), 64'h3E);
        chk("t1_frame", 64'(m1_frame), 64'h03_000000_00);
        chk("t1_latency", 64'(done_cyc - gnt_cyc), 64'd81);

        // Reset in the middle of a frame.
        repeat (4) tick();
        if_addr = 16'd2; if_req = 1'b1;
        for (int n = 0; n < 500 && m1_n < 20; n++) tick();
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        chk("t5_ce", 64'(spi_ce), 64'd1);
        chk("t5_sclk", 64'(spi_clk), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t5_no_done", 64'(dones), 64'd10);
        if_addr = 16'd1; if_req = 1'b1;
        wait_dones("t5_timeout", 11);
        if_req = 1'b0;
        chk("t5_rdata", 64'(rdata), 64'h03);

        // CLK_DIV=3 instance.
        if_addr3 = 16'd2; if_req3 = 1'b1;
        for (int n = 0; n < 1000 && dones3 < 1; n++) tick();
        if_req3 = 1'b0;
        chk("t6_done", 64'(dones3), 64'd1);
        chk("t6_latency", 64'(done3_cyc - gnt3_cyc), 64'd241);
        chk("t6_rdata", 64'(rdata3), 64'h26);
        chk("t6_frame", 64'(m3_frame), 64'h03_000002_00);
        chk("t6_run_min", 64'(rmin3), 64'd3);
        chk("t6_run_max", 64'(rmax3), 64'd3);
        chk("t6_mosi_stable", 64'(viol3), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
